// File: rtl/imem_loader_if.sv
// Bundle between the boot-loader control/byte stream and the instruction-memory write port.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;

    modport master (
        output load_start, load_len, in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done
    );

    modport slave (
        input  load_start, load_len, in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, busy, done
    );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to instruction
// memory, holding the CPU in reset until the requested number of words has been written.
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_idx;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_buf;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   w_len_eff;
    logic [ADDR_W:0]   w_idx_inc;
    logic              w_accept;
    logic              w_enter_load;

    assign w_len_eff    = (bus.load_len > DEPTH) ? DEPTH : bus.load_len;
    assign w_idx_inc    = r_idx + 1'b1;
    assign w_accept     = (r_state == S_LOAD) && bus.in_valid;
    assign w_enter_load = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.load_start
                          && (w_len_eff != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.load_start) begin
                    w_state_nxt = (w_len_eff == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.in_valid && (r_bcnt == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = (w_idx_inc == r_len) ? S_DONE : S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bytes 0..2 collect in r_buf; the visible word/address only change when byte 3 lands,
    // so imem_addr/imem_wdata are stable whenever imem_we is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_idx   <= '0;
            r_bcnt  <= '0;
            r_buf   <= '0;
            r_wdata <= '0;
            r_addr  <= '0;
        end else begin
            if (w_enter_load) begin
                r_idx  <= '0;
                r_bcnt <= '0;
                r_len  <= w_len_eff;
            end
            if (w_accept) begin
                r_bcnt <= r_bcnt + 2'd1;
                case (r_bcnt)
                    2'd0: r_buf[7:0]   <= bus.in_data;
                    2'd1: r_buf[15:8]  <= bus.in_data;
                    2'd2: r_buf[23:16] <= bus.in_data;
                    default: begin
                        r_wdata <= {bus.in_data, r_buf};
                        r_addr  <= r_idx[ADDR_W-1:0];
                    end
                endcase
            end
            if (r_state == S_WRITE) begin
                r_idx <= w_idx_inc;
            end
        end
    end

    assign bus.in_ready   = (r_state == S_LOAD);
    assign bus.imem_we    = (r_state == S_WRITE);
    assign bus.busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.cpu_rst_n  = (r_state == S_DONE);
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes are rebuilt from the byte stream that
// was offered, the effective length rule and the little-endian packing rule.
module tb_imem_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    typedef logic [AW:0] len_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    logic rst;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rdy_cnt  = 0;
    wr_t         wq[$];
    logic [7:0]  stim[32];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.imem_we) begin
                wr_t e;
                e.addr = int'(bus.imem_addr);
                e.data = bus.imem_wdata;
                e.cyc  = cyc;
                wq.push_back(e);
            end
            if (bus.in_ready) rdy_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, ":in_ready"},   bus.in_ready,   0);
        check_eq({tag, ":imem_we"},    bus.imem_we,    0);
        check_eq({tag, ":imem_addr"},  bus.imem_addr,  0);
        check_eq({tag, ":imem_wdata"}, bus.imem_wdata, 0);
        check_eq({tag, ":cpu_rst_n"},  bus.cpu_rst_n,  0);
        check_eq({tag, ":busy"},       bus.busy,       0);
        check_eq({tag, ":done"},       bus.done,       0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 32; i++) stim[i] = 8'($urandom);
    endtask

    // mode: 0 back-to-back bytes, 1 in_valid every other cycle, 2 random in_valid
    task automatic run_load(input int len, input int mode, input bit pulse_mid, input string tag);
        int          leff;
        int          nb;
        int          idx;
        int          guard;
        int          done_cyc;
        int          rdy0;
        bit          acc;
        bit          vld;
        bit          seen;
        logic [31:0] exp_word;

        leff = (len > DEPTH) ? DEPTH : len;
        nb   = 4 * leff;
        wq.delete();
        rdy0 = rdy_cnt;

        // in_valid is offered with load_start; that byte must not be taken
        @(posedge clk); #1;
        bus.load_start = 1'b1;
        bus.load_len   = len_t'(len);
        bus.in_valid   = 1'b1;
        bus.in_data    = 8'hA5;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;

        if (leff == 0) begin
            @(negedge clk);
            check_eq({tag, ":l0_done"},      bus.done,      1);
            check_eq({tag, ":l0_cpu_rst_n"}, bus.cpu_rst_n, 1);
            check_eq({tag, ":l0_busy"},      bus.busy,      0);
            repeat (3) @(negedge clk);
            check_eq({tag, ":l0_done_hold"}, bus.done,         1);
            check_eq({tag, ":l0_no_write"},  wq.size(),        0);
            check_eq({tag, ":l0_no_ready"},  rdy_cnt - rdy0,   0);
            return;
        end

        idx   = 0;
        guard = 0;
        while (idx < nb && guard < 16 * nb + 20) begin
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (guard % 2) == 0;
                default: vld = ($urandom_range(0, 1) == 1);
            endcase
            bus.in_valid   = vld;
            bus.in_data    = stim[idx];
            bus.load_start = pulse_mid && ($urandom_range(0, 3) == 0);
            bus.load_len   = len_t'($urandom_range(0, 2 * DEPTH - 1));
            @(negedge clk);
            if (guard == 0) begin
                check_eq({tag, ":first_ready"},  bus.in_ready,  1);
                check_eq({tag, ":load_rst_n"},   bus.cpu_rst_n, 0);
                check_eq({tag, ":load_busy"},    bus.busy,      1);
            end
            acc = vld && bus.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            guard++;
        end
        bus.in_valid   = 1'b0;
        bus.load_start = 1'b0;
        check_eq({tag, ":bytes_taken"}, idx, nb);

        seen     = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen     = 1'b1;
                done_cyc = cyc;
            end
        end
        check_eq({tag, ":done_seen"},   seen,          1);
        check_eq({tag, ":cpu_rst_n"},   bus.cpu_rst_n, 1);
        check_eq({tag, ":write_count"}, wq.size(),     leff);

        for (int i = 0; i < leff && i < wq.size(); i++) begin
            exp_word = {stim[4*i+3], stim[4*i+2], stim[4*i+1], stim[4*i]};
            check_eq({tag, ":addr"}, wq[i].addr, i);
            check_eq({tag, ":data"}, wq[i].data, exp_word);
            if (mode == 0 && i > 0) check_eq({tag, ":word_period"}, wq[i].cyc - wq[i-1].cyc, 5);
        end
        if (wq.size() > 0 && seen) check_eq({tag, ":done_latency"}, done_cyc - wq[wq.size()-1].cyc, 1);
    endtask

    task automatic reset_mid_load();
        wq.delete();
        fill_random();
        @(posedge clk); #1;
        bus.load_start = 1'b1;
        bus.load_len   = len_t'(1);
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = stim[0];
        @(posedge clk); #1;
        bus.in_data    = stim[1];
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset_vals("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("after_rst");
        check_eq("rst_no_write", wq.size(), 0);
        fill_random();
        run_load(1, 0, 0, "post_rst");
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.load_len   = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals("reset");

        run_load(0, 0, 0, "len0_idle");
        do_reset();

        stim[0] = 8'h13; stim[1] = 8'h00; stim[2] = 8'h00; stim[3] = 8'h00;
        stim[4] = 8'h93; stim[5] = 8'h00; stim[6] = 8'h10; stim[7] = 8'h00;
        run_load(2, 0, 0, "two_words");

        fill_random();
        run_load(1, 0, 0, "rearm");
        run_load(0, 0, 0, "len0_done");
        fill_random();
        run_load(7, 0, 0, "clamp7");
        fill_random();
        run_load(1, 1, 1, "alt_valid");

        for (int n = 0; n < 14; n++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            fill_random();
            run_load(int'($urandom_range(0, 2 * DEPTH - 1)), int'($urandom_range(0, 2)),
                     bit'($urandom_range(0, 1)), "rand");
        end

        reset_mid_load();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
